// File: rtl/crbar_pkg.sv
// Shared types and constants for the crbar_n crossbar.
package crbar_pkg;

    // Reconfiguration state: route normally, wait for empty outputs, commit new routing.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } crbar_state_e;

    // Width of each per-output accepted-beat counter.
    localparam int unsigned STAT_W = 16;

    // Ceiling log2, used to size the per-output source select.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int unsigned k = 0; k < 32; k++) begin
            if ((64'd1 << k) < 64'(value)) begin
                res = k + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/crbar_out_reg.sv
// One crossbar output slot: a single-entry register with valid/ready hold
// and an optional accepted-beat counter (enabled by the CRBAR_STATS_EN macro).
module crbar_out_reg
    import crbar_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [N-1:0]      load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [N-1:0]      out_data,
    output logic              can_acc,
    output logic [STAT_W-1:0] stat_cnt
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    // Slot is free if empty or its word retires this cycle.
    assign can_acc   = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;

    // Next state: load wins over retire so a retire plus load keeps the slot full.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

`ifdef CRBAR_STATS_EN
    logic [STAT_W-1:0] cnt_q, cnt_d;

    // Count every retired beat; wraps naturally at the counter width.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && out_ready) begin
            cnt_d = cnt_q + STAT_W'(1);
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stat_cnt = cnt_q;
`else
    assign stat_cnt = '0;
`endif

endmodule

// File: rtl/crbar_n.sv
// Registered CH x CH crossbar with valid/ready flow control, broadcast,
// per-output enables and drain-then-apply reconfiguration.
// Optional per-output beat counters are built when CRBAR_STATS_EN is defined.
module crbar_n
    import crbar_pkg::*;
#(
    parameter int unsigned Q  = 15,
    parameter int unsigned N  = 32,
    parameter int unsigned CH = 4,
    localparam int unsigned SW = clog2(CH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH*N-1:0]      in_data,
    input  logic [CH-1:0]        in_valid,
    output logic [CH-1:0]        in_ready,
    output logic [CH*N-1:0]      out_data,
    output logic [CH-1:0]        out_valid,
    input  logic [CH-1:0]        out_ready,
    input  logic [CH*SW-1:0]     cfg_sel,
    input  logic [CH-1:0]        cfg_en,
    input  logic                 cfg_we,
    output logic                 cfg_busy,
    output logic [CH*STAT_W-1:0] stat_cnt
);

    if (CH < 2 || (CH & (CH - 1)) != 0) begin : g_bad_ch
        $error("crbar_n: CH must be a power of two and at least 2");
    end
    if (Q >= N) begin : g_bad_q
        $error("crbar_n: Q must be smaller than N");
    end

    crbar_state_e           state_q, state_d;
    logic [CH-1:0][SW-1:0]  sel_q, sel_d;
    logic [CH-1:0][SW-1:0]  pend_sel_q, pend_sel_d;
    logic [CH-1:0]          en_q, en_d;
    logic [CH-1:0]          pend_en_q, pend_en_d;
    logic                   busy_q, busy_d;

    logic [N-1:0]           in_word [CH];
    logic [N-1:0]           src_word [CH];
    logic [CH-1:0]          can_acc;
    logic [CH-1:0]          load;
    logic [CH-1:0]          grp_hit, grp_ok;

    for (genvar i = 0; i < CH; i++) begin : g_in_word
        assign in_word[i] = in_data[i*N +: N];
    end

    // Broadcast-group ready: an input is ready only if every enabled output
    // routed from it can accept, so a group loads all-or-none.
    always_comb begin
        grp_hit = '0;
        grp_ok  = '1;
        for (int i = 0; i < CH; i++) begin
            for (int o = 0; o < CH; o++) begin
                if (en_q[o] && sel_q[o] == SW'(i)) begin
                    grp_hit[i] = 1'b1;
                    if (!can_acc[o]) begin
                        grp_ok[i] = 1'b0;
                    end
                end
            end
        end
        in_ready = (state_q == RUN) ? (grp_hit & grp_ok) : '0;
    end

    // Source mux and per-output load strobes.
    always_comb begin
        for (int o = 0; o < CH; o++) begin
            src_word[o] = in_word[sel_q[o]];
            load[o]     = en_q[o] && in_valid[sel_q[o]] && in_ready[sel_q[o]];
        end
    end

    for (genvar o = 0; o < CH; o++) begin : g_out
        crbar_out_reg #(
            .N(N)
        ) u_out_reg (
            .clk       (clk),
            .rst       (rst),
            .load      (load[o]),
            .load_data (src_word[o]),
            .out_ready (out_ready[o]),
            .out_valid (out_valid[o]),
            .out_data  (out_data[o*N +: N]),
            .can_acc   (can_acc[o]),
            .stat_cnt  (stat_cnt[o*STAT_W +: STAT_W])
        );
    end

    // Reconfiguration FSM next state: first write wins, routing only changes once outputs are empty.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        en_d       = en_q;
        pend_sel_d = pend_sel_q;
        pend_en_d  = pend_en_q;
        case (state_q)
            RUN: begin
                if (cfg_we) begin
                    for (int o = 0; o < CH; o++) begin
                        pend_sel_d[o] = cfg_sel[o*SW +: SW];
                    end
                    pend_en_d = cfg_en;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (out_valid == '0) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                sel_d   = pend_sel_q;
                en_d    = pend_en_q;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        busy_d = (state_d != RUN);
    end

    // FSM, routing and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            en_q       <= '1;
            pend_sel_q <= '0;
            pend_en_q  <= '0;
            busy_q     <= 1'b0;
            for (int o = 0; o < CH; o++) begin
                sel_q[o] <= SW'(o);
            end
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            en_q       <= en_d;
            pend_sel_q <= pend_sel_d;
            pend_en_q  <= pend_en_d;
            busy_q     <= busy_d;
        end
    end

    assign cfg_busy = busy_q;

endmodule
